bin2therm_dwa: RTL
==================

// Module: bin2therm_dwa
// PURPOSE
//  Registered, parametrised binary-to-thermometer converter with data-weighted
//  averaging (DWA) element rotation for unit-element DAC drive in the fractional
//  divider / DCO control path. Each accepted binary code selects that many unit
//  elements, starting at a rotating pointer, so mismatch error is first-order shaped.
// PARAMETERS
//  NBITS  5              binary input width
//  NOUT   2**NBITS-1     thermometer width / unit-element count (localparam, derived)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      input code valid this cycle
//  in         in   NBITS  binary code, 0..NOUT
//  ptr_clr    in   1      synchronous pointer clear
//  out        out  NOUT   rotated thermometer code, registered
//  out_valid  out  1      out updated this cycle
//  ptr        out  NBITS  current rotation pointer, 0..NOUT-1
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): out=0, out_valid=0, ptr=0.
//  - Latency 1: a code accepted at edge k appears on out/out_valid after edge k.
//  - in_valid=1: out <= therm(in) rotated left by ptr, i.e.
//    out[i] = (((i - ptr) mod NOUT) < in); ptr <= (ptr + in) mod NOUT.
//  - Modulo is NOUT (31 by default), never 2**NBITS: sum = ptr+in (NBITS+1 bits),
//    subtract NOUT once if sum >= NOUT.
//  - in_valid=0: out holds its last value, out_valid=0, ptr holds.
//  - in=0: out=0, ptr unchanged. in=NOUT: out all ones, ptr unchanged.
//  - ptr_clr=1: has priority over the stored pointer. With in_valid=1 in the same
//    cycle, the conversion uses ptr=0 and ptr <= in mod NOUT. Without in_valid,
//    ptr <= 0 and out holds.
//  - rst mid-stream: everything returns to its reset value immediately, and the
//    in-flight code is discarded.
//  - No FSM: state is the ptr register plus the output/valid register.
// CONFIGURATION
//  - Macro BIN2THERM_DWA_EN defined: rotation behaves as described above.
//  - Macro BIN2THERM_DWA_EN undefined: static thermometer. out <= therm(in) with bit 0
//    first, ptr is held at 0, and ptr_clr is ignored. Latency and valid behaviour are
//    unchanged.
// STRUCTURE
//  - Package bin2therm_pkg:
//    - function therm_code(code, NOUT), unrotated thermometer code;
//    - function rotl_mod(vec, sh, NOUT);
//    - function ptr_next(ptr, code, NOUT).
//  - One sub-module, bin2therm_comb: parametrised combinational binary-to-thermometer
//    stage. It is instantiated once, and its output feeds the rotator and register.
// TESTING
//  Directed scenarios, all with NBITS=5 and DWA enabled unless stated:
//  1. Assert rst with in_valid=1 and in=7 -> out=0, out_valid=0, ptr=0 throughout.
//  2. From ptr=0, in=5 -> out=0x0000_001F, ptr=5; then in=3 -> out=0x0000_00E0,
//     ptr=8; out_valid is high one cycle after each input.
//  3. Wrap: ptr=28, in=6 -> out=0x7000_0007, ptr=3. Then in=31 -> out=0x7FFF_FFFF,
//     ptr=3. Then in=0 -> out=0, ptr=3.
//  4. ptr=20, ptr_clr=1 with in_valid=1 and in=4 -> out=0x0000_000F, ptr=4.
//     ptr_clr alone -> ptr=0, out holds.
//  5. Idle: in_valid=0 for 3 cycles after out=0x0000_00E0 -> out holds, out_valid=0,
//     ptr holds. Pulse rst mid-stream -> all outputs clear asynchronously.
//  6. Build without BIN2THERM_DWA_EN: in=5,3,31 -> out=0x1F, 0x07, 0x7FFF_FFFF;
//     ptr stays 0.
//  Also check the sum of set bits of out equals the accepted in on every valid
//  cycle, in random streams of 10k codes.

Source files
------------

// File: rtl/bin2therm_pkg.sv
// Shared helpers for the binary-to-thermometer DWA converter.
// Vectors are carried at MAXW bits; callers slice them down to NOUT.
package bin2therm_pkg;

    localparam int unsigned MAXW = 64;

    typedef logic [MAXW-1:0] vec_t;

    function automatic vec_t therm_code(input int unsigned code, input int unsigned nout);
        vec_t r;
        r = '0;
        for (int unsigned i = 0; i < MAXW; i++)
            r[i[5:0]] = (i < nout) && (i < code);
        return r;
    endfunction

    // Rotate left by sh within an nout-wide ring; sh is always below nout.
    function automatic vec_t rotl_mod(input vec_t v, input int unsigned sh, input int unsigned nout);
        vec_t r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (i < nout) begin
                j = i + nout - sh;
                if (j >= nout)
                    j = j - nout;
                r[i[5:0]] = v[j[5:0]];
            end
        end
        return r;
    endfunction

    // ptr + code never exceeds 2*nout-1, so one conditional subtract suffices.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned code,
                                             input int unsigned nout);
        int unsigned sum;
        sum = ptr + code;
        if (sum >= nout)
            sum = sum - nout;
        return sum;
    endfunction

endpackage

// File: rtl/bin2therm_comb.sv
// Combinational binary-to-thermometer stage, bit 0 first.
module bin2therm_comb #(
    parameter int NBITS = 5
) (
    input  logic [NBITS-1:0]     code,
    output logic [2**NBITS-2:0]  therm
);
    import bin2therm_pkg::*;

    localparam int NOUT = 2**NBITS - 1;

    assign therm = NOUT'(therm_code(32'(code), NOUT));

endmodule

// File: rtl/bin2therm_dwa.sv
// Registered binary-to-thermometer converter with DWA element rotation.
// Define BIN2THERM_DWA_EN for rotation; otherwise a static thermometer with ptr held at 0.
module bin2therm_dwa #(
    parameter int NBITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NBITS-1:0]     in,
    input  logic                 ptr_clr,
    output logic [2**NBITS-2:0]  out,
    output logic                 out_valid,
    output logic [NBITS-1:0]     ptr
);
    import bin2therm_pkg::*;

    localparam int NOUT = 2**NBITS - 1;

    logic [NOUT-1:0]  therm;
    logic [NOUT-1:0]  out_d;
    logic [NBITS-1:0] ptr_d;
    logic [NBITS-1:0] ptr_idle;

    bin2therm_comb #(.NBITS(NBITS)) u_comb (
        .code  (in),
        .therm (therm)
    );

`ifdef BIN2THERM_DWA_EN
    logic [NBITS-1:0] ptr_eff;

    // A clear in the same cycle as a code rotates from element 0.
    assign ptr_eff  = ptr_clr ? '0 : ptr;
    assign out_d    = NOUT'(rotl_mod(vec_t'(therm), 32'(ptr_eff), NOUT));
    assign ptr_d    = NBITS'(ptr_next(32'(ptr_eff), 32'(in), NOUT));
    assign ptr_idle = ptr_clr ? '0 : ptr;
`else
    logic unused_ptr_clr;

    assign unused_ptr_clr = ptr_clr;
    assign out_d          = therm;
    assign ptr_d          = '0;
    assign ptr_idle       = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= out_d;
                ptr <= ptr_d;
            end else begin
                ptr <= ptr_idle;
            end
        end
    end

endmodule
